decoder_nto2n_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder that succeeds the fixed 3-to-8 combinational decoder in comb_ckts/decoders.

---
 rtl/decoder_nto2n_seq_pkg.sv | 11 +
 rtl/decoder_dwell_cnt.sv | 46 ++++
 rtl/decoder_nto2n_seq.sv | 101 ++++++++++
 tb/tb_decoder_nto2n_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_nto2n_seq_pkg.sv
// Shared definitions for the N-to-2^N sequenced decoder family.
// Contents: mode encoding used by the top level and by the bench.
package decoder_nto2n_seq_pkg;

  // Operating mode, as carried on the 'mode' input.
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

endpackage : decoder_nto2n_seq_pkg

// File: rtl/decoder_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while run=1 and wraps to 0.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force the count to 0 (wins over run)
//   run      : advance the count this cycle
//   tick     : combinational, high on the cycle the count sits at DWELL-1
//              while running (the cycle the owner should step)
module decoder_dwell_cnt #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned DW_W = $clog2(DWELL) + 1;
  localparam logic [DW_W-1:0] LAST = DW_W'(DWELL - 1);

  logic [DW_W-1:0] cnt_q;
  logic [DW_W-1:0] cnt_d;

  // A clear cancels any step that would otherwise fire this cycle.
  assign tick = run && !clr && (cnt_q == LAST);

  // Next count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DW_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : decoder_dwell_cnt

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with direct and scan modes.
// Optional build macro: DECODER_ACTIVE_LOW_EN makes OUT one-cold
// (reset and en=0 then drive OUT to all-ones).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : output enable; 0 blanks OUT and suppresses pulses only
//   mode      : 0 = direct decode of IN, 1 = autonomous scan
//   in_valid  : load IN into sel_q (both modes)
//   IN        : select value
//   OUT       : registered one-hot of sel_q
//   out_valid : one-cycle pulse when OUT takes a new position
//   sel_q     : currently decoded select
//   wrap      : one-cycle pulse on a scan step from OUT_W-1 to 0
module decoder_nto2n_seq
  import decoder_nto2n_seq_pkg::*;
#(
  parameter  int unsigned SEL_W = 3,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] IN,
  output logic [OUT_W-1:0] OUT,
  output logic             out_valid,
  output logic [SEL_W-1:0] sel_q,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] SEL_MAX = '1;
`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] OUT_IDLE = '1;
`else
  localparam logic [OUT_W-1:0] OUT_IDLE = '0;
`endif

  logic             mode_q;
  logic             scan;
  logic             mode_chg;
  logic             cnt_clr;
  logic             tick;
  logic [SEL_W-1:0] sel_d;
  logic             ov_d;
  logic             wrap_d;
  logic [OUT_W-1:0] out_d;

  assign scan     = (mode_e'(mode) == MODE_SCAN);
  assign mode_chg = (mode != mode_q);
  // Dwell only runs in scan; loads and mode changes restart it.
  assign cnt_clr  = in_valid || mode_chg || !scan;

  decoder_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .run  (scan),
    .tick (tick)
  );

  // Next select and output pulses; a load has priority over a scan step.
  always_comb begin
    sel_d  = sel_q;
    ov_d   = 1'b0;
    wrap_d = 1'b0;
    if (in_valid) begin
      sel_d = IN;
      ov_d  = en;
    end else if (tick) begin
      sel_d  = sel_q + SEL_W'(1);
      ov_d   = en;
      wrap_d = en && (sel_q == SEL_MAX);
    end
    out_d = en ? (OUT_W'(1) << sel_d) : '0;
`ifdef DECODER_ACTIVE_LOW_EN
    out_d = ~out_d;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_DIRECT;
      sel_q     <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      OUT       <= OUT_IDLE;
    end else begin
      mode_q    <= mode;
      sel_q     <= sel_d;
      out_valid <= ov_d;
      wrap      <= wrap_d;
      OUT       <= out_d;
    end
  end

endmodule : decoder_nto2n_seq

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench for decoder_nto2n_seq (SEL_W=3, DWELL=4).
// Honours DECODER_ACTIVE_LOW_EN by inverting expected OUT values.
module tb_decoder_nto2n_seq;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned DWELL = 4;
  localparam int unsigned OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, mode, in_valid;
  logic [SEL_W-1:0] IN;
  logic [OUT_W-1:0] OUT;
  logic             out_valid, wrap;
  logic [SEL_W-1:0] sel_q;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .IN        (IN),
    .OUT       (OUT),
    .out_valid (out_valid),
    .sel_q     (sel_q),
    .wrap      (wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] pol(input logic [OUT_W-1:0] x);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  // Behavioural model: position index plus cycles elapsed in the current dwell.
  int              m_sel  = 0;
  int              m_ph   = 0;
  bit              m_mode = 1'b0;
  logic [OUT_W-1:0] m_out = '0;
  bit              m_ov   = 1'b0;
  bit              m_wrap = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_sel = 0; m_ph = 0; m_mode = 1'b0; m_ov = 1'b0; m_wrap = 1'b0;
    end else begin
      m_ov = 1'b0;
      m_wrap = 1'b0;
      if (in_valid) begin
        m_sel = int'(IN);
        m_ph  = 0;
        m_ov  = en;
      end else if (mode && (mode == m_mode)) begin
        m_ph = m_ph + 1;
        if (m_ph == DWELL) begin
          m_ph   = 0;
          m_wrap = en && (m_sel == OUT_W - 1);
          m_sel  = (m_sel + 1) % OUT_W;
          m_ov   = en;
        end
      end else begin
        m_ph = 0;
      end
      m_mode = mode;
    end
    m_out = (!rst && en) ? pol(OUT_W'(1) << m_sel) : pol('0);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_out",   32'(OUT),       32'(m_out));
      chk("model_ov",    32'(out_valid), 32'(m_ov));
      chk("model_wrap",  32'(wrap),      32'(m_wrap));
      chk("model_sel",   32'(sel_q),     32'(m_sel));
    end
  end

  task automatic cyc(input logic r, input logic e, input logic m, input logic v,
                     input logic [SEL_W-1:0] s);
    rst = r; en = e; mode = m; in_valid = v; IN = s;
    @(negedge clk);
  endtask

  int n_ov, n_wrap;

  initial begin
    // Reset with a pending load: reset must win.
    cyc(1, 1, 0, 1, 3'd5);
    chk_on = 1'b1;
    cyc(1, 1, 0, 1, 3'd5);
    chk("rst_out", 32'(OUT), 32'(pol(8'h00)));
    chk("rst_ov",  32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel_q), 32'd0);
    cyc(0, 1, 0, 1, 3'd5);
    chk("first_load_out", 32'(OUT), 32'(pol(8'h20)));
    chk("first_load_ov",  32'(out_valid), 32'd1);

    // Direct sweep, then a repeated value and an idle hold.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 1, SEL_W'(i));
      chk("sweep_out", 32'(OUT), 32'(pol(OUT_W'(1) << i)));
      chk("sweep_ov",  32'(out_valid), 32'd1);
    end
    cyc(0, 1, 0, 1, 3'd7);
    chk("repeat_ov", 32'(out_valid), 32'd1);
    cyc(0, 1, 0, 0, 3'd0);
    chk("hold_ov",  32'(out_valid), 32'd0);
    chk("hold_sel", 32'(sel_q), 32'd7);
    repeat (6) cyc(0, 1, 0, 0, 3'd0);

    // Scan: load 0 on entry, one full 32-cycle period ends on the wrap.
    cyc(0, 1, 1, 1, 3'd0);
    chk("scan_load_out", 32'(OUT), 32'(pol(8'h01)));
    n_ov = 0; n_wrap = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 1, 0, 3'd0);
      n_ov += int'(out_valid);
      n_wrap += int'(wrap);
    end
    chk("period_steps", 32'(n_ov), 32'd8);
    chk("period_wraps", 32'(n_wrap), 32'd1);
    chk("wrap_out",     32'(OUT), 32'(pol(8'h01)));
    chk("wrap_pulse",   32'(wrap), 32'd1);

    // Load collides with the step to 6.
    repeat (23) cyc(0, 1, 1, 0, 3'd0);
    chk("pre_collide_sel", 32'(sel_q), 32'd5);
    cyc(0, 1, 1, 1, 3'd2);
    chk("collide_sel",  32'(sel_q), 32'd2);
    chk("collide_out",  32'(OUT), 32'(pol(8'h04)));
    chk("collide_wrap", 32'(wrap), 32'd0);
    chk("collide_ov",   32'(out_valid), 32'd1);
    repeat (3) cyc(0, 1, 1, 0, 3'd0);
    chk("post_collide_hold", 32'(sel_q), 32'd2);
    cyc(0, 1, 1, 0, 3'd0);
    chk("post_collide_step", 32'(sel_q), 32'd3);

    // Enable gating for 10 cycles while scanning.
    n_ov = 0; n_wrap = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0, 3'd0);
      n_ov += int'(out_valid);
      n_wrap += int'(wrap);
    end
    chk("gated_out",    32'(OUT), 32'(pol(8'h00)));
    chk("gated_pulses", 32'(n_ov + n_wrap), 32'd0);
    cyc(0, 1, 1, 0, 3'd0);
    chk("ungated_out", 32'(OUT), 32'(pol(8'h20)));

    // Mode changes mid-scan, then scan re-entry.
    repeat (3) cyc(0, 1, 0, 0, 3'd0);
    chk("to_direct_sel", 32'(sel_q), 32'd5);
    repeat (9) cyc(0, 1, 1, 0, 3'd0);

    // Direct load while disabled, then re-enable.
    cyc(0, 0, 0, 1, 3'd6);
    chk("dis_load_out", 32'(OUT), 32'(pol(8'h00)));
    chk("dis_load_ov",  32'(out_valid), 32'd0);
    cyc(0, 1, 0, 0, 3'd0);
    chk("reen_out", 32'(OUT), 32'(pol(8'h40)));

    // Reset in the middle of a scan.
    repeat (5) cyc(0, 1, 1, 0, 3'd0);
    cyc(1, 1, 1, 0, 3'd0);
    chk("midscan_rst_out", 32'(OUT), 32'(pol(8'h00)));
    chk("midscan_rst_sel", 32'(sel_q), 32'd0);
    repeat (6) cyc(0, 1, 1, 0, 3'd0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_decoder_nto2n_seq
